barcode_tx: RTL and testbench
=============================

# barcode_tx

Barcode transmitter: serialises an 8-bit station ID onto the single-wire BC line using the same pulse-width code the barcode reader decodes. It is used as the stimulus source for reader loopback benches and as the station-beacon driver in the track emulator. On a `send` strobe it captures the ID and a programmable half-period H, then drives a start cell followed by 8 data cells, MSB first. It reports `busy` while transmitting and pulses `done` at the end of the frame.

## Interface
- `CNT_W`, 22: width of the half-period input.
- `MIN_HALF`, 4: smallest legal H. A captured H below this value is replaced by `MIN_HALF`.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `send`  in  1: start-frame strobe; sampled every cycle.
- `tx_id`  in  8: ID to transmit; captured when `send` is accepted.
- `half_per`  in  CNT_W: half-period H in clk cycles; captured when `send` is accepted.
- `BC`  out  1: serial barcode line. Idle is high; low represents black.
- `busy`  out  1: high while a frame is in flight.
- `done`  out  1: one-cycle pulse when a frame completes.

## Operation
- Reset values: `BC`=1, `busy`=0, `done`=0, state IDLE, all counters 0. Reset takes effect immediately mid-frame: `BC` returns high and the frame is abandoned with no `done` pulse.
- Cell timing: every cell is 2H cycles long and always begins with a falling edge on `BC`.
  - Start cell: low for H, then high for H.
  - Data 1: low for L1 = H>>1 (floor), then high for 2H−L1.
  - Data 0: low for L0 = H + (H>>1), then high for 2H−L0.
  - The reader samples near H after each falling edge. It therefore sees 1 for short-low cells and 0 for long-low cells.
- Bit order: `tx_id[7]` goes first and `tx_id[0]` last. No stop cell; `BC` stays high after the last cell.
- States:
  - IDLE → START_LO on accepted `send`.
  - START_LO → START_HI after H cycles.
  - START_HI → BIT_LO after H cycles.
  - BIT_LO → BIT_HI after L(bit) cycles.
  - BIT_HI → BIT_LO after 2H−L(bit) cycles while bits remain.
  - BIT_HI → IDLE with a `done` pulse after bit 0.
- Phase counter: one counter of width CNT_W+1 (it must hold 3H/2), cleared on every phase change. The phase ends when the count equals the phase length − 1.
- Bit counter: 3 bits, decremented from 7 at the end of each BIT_HI. The ID shift register shifts left at the same point.
- Capture: `tx_id` and the clamped H are registered on acceptance. Later changes to `tx_id`/`half_per` have no effect on the frame in flight.
- `send` while `busy`=1 is ignored; it is not queued. `send` held high continuously produces back-to-back frames: a new frame is accepted in the cycle after `done`.
- `BC` is driven directly from a flop (glitch-free).

## Timing
- `send` sampled high in cycle N (IDLE) → `BC` falls at edge N+1, and `busy` rises at edge N+1.
- Frame length: exactly 18H cycles of `busy`=1. `BC` is low/high in the exact cycle counts given above, with no ±1 slack.
- `done` is high for the single cycle in which `busy` goes low (edge N+1+18H). `BC` is already high at that point.
- Clamp: H<`MIN_HALF` → H=`MIN_HALF`, so the minimum frame is 72 cycles.
- Odd H: L1=(H−1)/2 and L0=H+(H−1)/2. The cell length remains exactly 2H.
- Max H = 2^CNT_W−1; L0 must not overflow the CNT_W+1 counter.

## Test plan
- H=8, `tx_id`=0x2A. Required `BC` waveform: low 8/high 8, then the cells 0,0,1,0,1,0,1,0 with low widths 12,12,4,12,4,12,4,12 and high widths 4,4,12,4,12,4,12,4. `busy` high for 144 cycles, then a single `done` pulse.
- Loopback into the barcode reader with H=1000 and `tx_id`=0x25 → reader ID=0x25 and ID_vld=1. Repeat with 0xC5 → reader returns to idle with ID_vld=0.
- Pulse `send` with 0x11 at cycle 50 of an active 0x3F frame → the first frame completes unaltered and no second frame follows. Then hold `send` high for 2 frames → the second falling edge starts exactly 1 cycle after `done`.
- Odd/clamp: H=9 → low widths 4 (bit 1) and 13 (bit 0), cell 18. H=2 → timing identical to H=4 (frame 72 cycles).
- Assert `rst_n` low mid-data-cell while `BC`=0 → `BC`=1, `busy`=0, and `done`=0 immediately. After release, a new `send` produces a correct full frame.

Source files
------------

// File: rtl/barcode_tx.sv
// barcode_tx: serialises an 8-bit station ID onto the single-wire BC line.
// A frame is one start cell followed by 8 data cells, MSB first. Each cell
// is 2H cycles long and starts with a falling edge. Short-low cells carry a
// 1 and long-low cells carry a 0.
module barcode_tx #(
    parameter int CNT_W    = 22,
    parameter int MIN_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [7:0]       tx_id,
    input  logic [CNT_W-1:0] half_per,
    output logic             BC,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        START_LO,
        START_HI,
        BIT_LO,
        BIT_HI
    } state_t;

    localparam logic [CNT_W:0]   ONE      = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_H    = CNT_W'(MIN_HALF);

    state_t           state_reg, state_next;
    logic [CNT_W:0]   phase_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] half_reg;
    logic             bc_reg, busy_reg, done_reg;

    logic [CNT_W-1:0] half_clamped;
    logic [CNT_W:0]   half_ext, low_len, phase_len;
    logic             phase_end, accept, bit_end;

    // Out-of-range half-periods are raised to the minimum at capture time.
    assign half_clamped = (half_per < MIN_H) ? MIN_H : half_per;

    // The counter is one bit wider than H so that 3H/2 and 2H both fit.
    assign half_ext = {1'b0, half_reg};
    assign low_len  = shift_reg[7] ? (half_ext >> 1) : (half_ext + (half_ext >> 1));

    assign accept  = (state_reg == IDLE) && send;
    assign bit_end = (state_reg == BIT_HI) && phase_end;

    // Select the length of the current phase; the high part of a data
    // cell absorbs whatever the low part did not use.
    always_comb begin
        phase_len = half_ext;
        case (state_reg)
            START_LO: phase_len = half_ext;
            START_HI: phase_len = half_ext;
            BIT_LO:   phase_len = low_len;
            BIT_HI:   phase_len = (half_ext << 1) - low_len;
            default:  phase_len = half_ext;
        endcase
    end

    assign phase_end = (phase_cnt_reg == (phase_len - ONE));

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (send)      state_next = START_LO;
            START_LO: if (phase_end) state_next = START_HI;
            START_HI: if (phase_end) state_next = BIT_LO;
            BIT_LO:   if (phase_end) state_next = BIT_HI;
            BIT_HI:   if (phase_end) state_next = (bit_cnt_reg == 3'd0) ? IDLE : BIT_LO;
            default:  state_next = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state, so BC,
    // busy and done come straight from flops and change on the same edge
    // as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bc_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bc_reg    <= !((state_next == START_LO) || (state_next == BIT_LO));
            busy_reg  <= (state_next != IDLE);
            done_reg  <= bit_end && (bit_cnt_reg == 3'd0);
        end
    end

    // Phase counter restarts on every phase change and stays cleared in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_reg <= '0;
        end else if ((state_reg == IDLE) || phase_end) begin
            phase_cnt_reg <= '0;
        end else begin
            phase_cnt_reg <= phase_cnt_reg + ONE;
        end
    end

    // Frame parameters are captured on acceptance; the ID shifts out MSB
    // first, one bit per completed data cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
            half_reg    <= '0;
        end else if (accept) begin
            bit_cnt_reg <= 3'd7;
            shift_reg   <= tx_id;
            half_reg    <= half_clamped;
        end else if (bit_end) begin
            bit_cnt_reg <= bit_cnt_reg - 3'd1;
            shift_reg   <= {shift_reg[6:0], 1'b0};
        end
    end

    assign BC   = bc_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_barcode_tx.sv
// Testbench for barcode_tx: frames are pushed to a scoreboard when a send
// is driven; a negedge monitor pops them when busy rises and compares every
// BC run length, the frame length, the done pulse and the decoded ID.
module tb_barcode_tx;

    localparam int CNT_W = 22;

    logic             clk;
    logic             rst_n;
    logic             send;
    logic [7:0]       tx_id;
    logic [CNT_W-1:0] half_per;
    logic             BC;
    logic             busy;
    logic             done;

    barcode_tx #(.CNT_W(CNT_W), .MIN_HALF(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .tx_id    (tx_id),
        .half_per (half_per),
        .BC       (BC),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        int         h;
    } frame_t;

    frame_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- monitor state ----------------
    int         cyc = 0;
    logic       prev_busy = 1'b0;
    logic       in_frame = 1'b0;
    frame_t     cur;
    int         exp_lvl[18];
    int         exp_len[18];
    int         seg = 0;
    int         run = 0;
    logic       run_lvl = 1'b1;
    int         busy_len = 0;
    logic [7:0] dec = 8'd0;
    int         frames_done = 0;
    int         last_done_cyc = -1;
    logic       b2b_mode = 1'b0;

    task automatic build_expected(input frame_t f);
        int lo;
        exp_lvl[0] = 0; exp_len[0] = f.h;
        exp_lvl[1] = 1; exp_len[1] = f.h;
        for (int i = 0; i < 8; i++) begin
            lo = f.id[7-i] ? (f.h / 2) : (f.h + f.h / 2);
            exp_lvl[2+2*i] = 0; exp_len[2+2*i] = lo;
            exp_lvl[3+2*i] = 1; exp_len[3+2*i] = 2 * f.h - lo;
        end
    endtask

    task automatic emit();
        if (seg < 18) begin
            chk($sformatf("seg%0d_lvl id=%02h", seg, cur.id), int'(run_lvl), exp_lvl[seg]);
            chk($sformatf("seg%0d_len id=%02h", seg, cur.id), run, exp_len[seg]);
            if (seg >= 2 && run_lvl == 1'b0)
                dec = {dec[6:0], (run < cur.h) ? 1'b1 : 1'b0};
        end else begin
            chk("extra_segment", seg, 17);
        end
        seg++;
    endtask

    always @(negedge clk) begin
        logic fall;
        cyc++;
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            fall = prev_busy && !busy;
            if (done && !fall)
                chk("spurious_done", int'(done), 0);
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    in_frame = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    build_expected(cur);
                    in_frame = 1'b1;
                    seg      = 0;
                    run      = 1;
                    run_lvl  = BC;
                    busy_len = 1;
                    dec      = 8'd0;
                    if (b2b_mode && last_done_cyc >= 0)
                        chk("b2b_gap", cyc - last_done_cyc, 1);
                end
            end else if (busy && in_frame) begin
                busy_len++;
                if (BC == run_lvl) begin
                    run++;
                end else begin
                    emit();
                    run     = 1;
                    run_lvl = BC;
                end
            end else if (fall) begin
                chk("done_at_end", int'(done), 1);
                last_done_cyc = cyc;
                if (in_frame) begin
                    emit();
                    chk("seg_count", seg, 18);
                    chk("busy_len", busy_len, 18 * cur.h);
                    chk("bc_high_at_end", int'(BC), 1);
                    chk($sformatf("decoded_id sent=%02h", cur.id), int'(dec), int'(cur.id));
                    $display("frame id=%02h h=%0d len=%0d decoded=%02h", cur.id, cur.h, busy_len, dec);
                    frames_done++;
                end
                in_frame = 1'b0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    function automatic int clamp_h(input int hp);
        return (hp < 4) ? 4 : hp;
    endfunction

    task automatic send_frame(input logic [7:0] id, input int hp);
        frame_t f;
        @(negedge clk);
        send     = 1'b1;
        tx_id    = id;
        half_per = CNT_W'(hp);
        f.id = id;
        f.h  = clamp_h(hp);
        exp_q.push_back(f);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames_done >= n) break;
            @(negedge clk);
        end
        chk($sformatf("frames_reached_%0d", n), int'(frames_done >= n), 1);
    endtask

    initial begin
        frame_t f;
        int     n_done;
        rst_n    = 1'b0;
        send     = 1'b0;
        tx_id    = 8'd0;
        half_per = '0;

        repeat (3) @(negedge clk);
        chk("reset_bc", int'(BC), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        // Basic frame, then the two loopback IDs at a long half-period.
        send_frame(8'h2A, 8);
        wait_frames(1, 400);
        send_frame(8'h25, 1000);
        wait_frames(2, 20000);
        send_frame(8'hC5, 1000);
        wait_frames(3, 20000);

        // A send mid-frame with new inputs must be ignored and not queued.
        send_frame(8'h3F, 8);
        repeat (48) @(negedge clk);
        tx_id    = 8'h11;
        half_per = CNT_W'(5);
        send     = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_frames(4, 400);
        repeat (200) @(negedge clk);
        chk("no_second_frame_busy", int'(busy), 0);

        // Held send: two back-to-back frames, restart one cycle after done.
        last_done_cyc = -1;
        b2b_mode      = 1'b1;
        @(negedge clk);
        send     = 1'b1;
        tx_id    = 8'h96;
        half_per = CNT_W'(6);
        f.id = 8'h96;
        f.h  = 6;
        exp_q.push_back(f);
        exp_q.push_back(f);
        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (n_done == 2) break;
        end
        send = 1'b0;
        chk("held_send_done_pulses", n_done, 2);
        wait_frames(6, 50);
        b2b_mode = 1'b0;

        // Odd half-period and clamped half-periods.
        send_frame(8'h5A, 9);
        wait_frames(7, 400);
        send_frame(8'h81, 2);
        wait_frames(8, 400);
        send_frame(8'hE7, 0);
        wait_frames(9, 400);

        // Reset in the middle of a low data cell abandons the frame.
        send_frame(8'h00, 8);
        repeat (20) @(negedge clk);
        chk("pre_reset_bc_low", int'(BC), 0);
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_bc", int'(BC), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        chk("midreset_done_held", int'(done), 0);
        rst_n = 1'b1;
        send_frame(8'hB4, 5);
        wait_frames(10, 400);
        repeat (5) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frames_total", frames_done, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
